// File: rtl/astro_pkg.sv
// Shared constants for the Astrocade ROM arbiter: region map and FSM encoding.
package astro_pkg;

    localparam logic [13:0] BIOS_BASE   = 14'h0000;
    localparam logic [13:0] CART_BASE   = 14'h2000;
    localparam int          REGION_SIZE = 8192;

    // State encoding kept as plain constants so older code that compares
    // raw 2-bit values keeps working.
    //  state    | meaning
    //  ST_IDLE  | serve BIOS/cart reads from the shared memory
    //  ST_LOAD  | download active, waiting for a word strobe
    //  ST_HI    | write the high byte of the latched word, ioctl_wait high
    //  ST_FILL  | pad the rest of the cartridge region with FILL_BYTE
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_HI   = 2'd2;
    localparam state_t ST_FILL = 2'd3;

endpackage

// File: rtl/rom_load_arbiter.sv
// Shared BIOS/cartridge ROM arbiter: unpacks HPS download words into byte
// writes, pads short cartridges, and serves two registered read ports.
module rom_load_arbiter
    import astro_pkg::*;
#(
    parameter int          REGION_AW = 13,
    parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [15:0]          ioctl_dout,
    output logic                 ioctl_wait,
    input  logic [REGION_AW-1:0] bios_addr,
    input  logic                 bios_cs_n,
    output logic [7:0]           bios_do,
    input  logic [REGION_AW-1:0] cart_addr,
    input  logic                 cart_cs_n,
    output logic [7:0]           cart_do,
    output logic [REGION_AW:0]   mem_addr,
    output logic [7:0]           mem_din,
    output logic                 mem_we,
    input  logic [7:0]           mem_q,
    output logic [13:0]          cart_size,
    output logic                 busy
);

    localparam logic [REGION_AW-1:0] REGION_LAST = '1;

    state_t                state_q, state_d;
    logic                  dl_q, dl_d;
    logic [15:0]           word_q, word_d;
    logic [24:0]           addr_q, addr_d;
    logic                  cart_q, cart_d;
    logic                  last_cart_q, last_cart_d;
    logic [13:0]           cart_size_q, cart_size_d;
    logic [REGION_AW-1:0]  fill_n_q, fill_n_d;
    logic                  bios_gnt_q, bios_gnt_d;
    logic                  cart_gnt_q, cart_gnt_d;
    logic [7:0]            bios_do_q, bios_do_d;
    logic [7:0]            cart_do_q, cart_do_d;

    logic                  dl_rise, dl_fall;
    logic                  idx_ok, idx_cart;
    logic                  wr_in_range, hi_in_range;
    logic [25:0]           end_w;
    logic [13:0]           end_sat;
    logic [13:0]           size_after_hi;
    logic [7:0]            cap_data;

    // Download edges, index decode and the saturating cartridge high-water mark.
    always_comb begin
        dl_rise       = ioctl_download & ~dl_q;
        dl_fall       = ~ioctl_download & dl_q;
        idx_cart      = (ioctl_index == 8'd1);
        idx_ok        = (ioctl_index == 8'd0) || idx_cart;
        wr_in_range   = (ioctl_addr < 25'(REGION_SIZE));
        hi_in_range   = (addr_q < 25'(REGION_SIZE));
        end_w         = {1'b0, addr_q} + 26'd2;
        end_sat       = (end_w >= 26'(REGION_SIZE)) ? 14'(REGION_SIZE) : end_w[13:0];
        size_after_hi = (cart_q && (end_sat > cart_size_q)) ? end_sat : cart_size_q;
    end

    // Sequencer: memory port mux, download unpacking and cartridge padding.
    always_comb begin
        state_d     = state_q;
        dl_d        = ioctl_download;
        word_d      = word_q;
        addr_d      = addr_q;
        cart_d      = cart_q;
        last_cart_d = last_cart_q;
        cart_size_d = cart_size_q;
        fill_n_d    = fill_n_q;
        mem_addr    = '0;
        mem_din     = 8'h00;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bios_cs_n) begin
                    mem_addr = BIOS_BASE | {1'b0, bios_addr};
                end else if (!cart_cs_n) begin
                    mem_addr = CART_BASE | {1'b0, cart_addr};
                end
                if (dl_rise) begin
                    state_d     = ST_LOAD;
                    last_cart_d = idx_cart;
                    if (idx_cart) begin
                        cart_size_d = '0;
                    end
                end
            end

            ST_LOAD: begin
                if (dl_fall) begin
                    if (last_cart_q && (cart_size_q < 14'(REGION_SIZE))) begin
                        state_d  = ST_FILL;
                        fill_n_d = cart_size_q[REGION_AW-1:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (ioctl_wr && idx_ok) begin
                    word_d      = ioctl_dout;
                    addr_d      = ioctl_addr;
                    cart_d      = idx_cart;
                    last_cart_d = idx_cart;
                    mem_addr    = {ioctl_index[0], ioctl_addr[REGION_AW-1:0]};
                    mem_din     = ioctl_dout[7:0];
                    mem_we      = wr_in_range;
                    state_d     = ST_HI;
                end
            end

            ST_HI: begin
                // Address is even, so +1 never carries out of the region.
                mem_addr    = {cart_q, addr_q[REGION_AW-1:0] + 1'b1};
                mem_din     = word_q[15:8];
                mem_we      = hi_in_range;
                cart_size_d = size_after_hi;
                if (dl_fall) begin
                    if (last_cart_q && (size_after_hi < 14'(REGION_SIZE))) begin
                        state_d  = ST_FILL;
                        fill_n_d = size_after_hi[REGION_AW-1:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_FILL: begin
                if (dl_rise) begin
                    state_d     = ST_LOAD;
                    last_cart_d = idx_cart;
                    if (idx_cart) begin
                        cart_size_d = '0;
                    end
                end else begin
                    mem_addr = CART_BASE | {1'b0, fill_n_q};
                    mem_din  = FILL_BYTE;
                    mem_we   = 1'b1;
                    if (fill_n_q == REGION_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        fill_n_d = fill_n_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Read return path: remember who was granted, capture mem_q one cycle later.
    always_comb begin
        bios_gnt_d = (state_q == ST_IDLE) && !bios_cs_n;
        cart_gnt_d = (state_q == ST_IDLE) && bios_cs_n && !cart_cs_n;
        cap_data   = (state_q == ST_IDLE) ? mem_q : 8'hFF;
        bios_do_d  = bios_gnt_q ? cap_data : bios_do_q;
        cart_do_d  = cart_gnt_q ? cap_data : cart_do_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dl_q        <= 1'b0;
            word_q      <= '0;
            addr_q      <= '0;
            cart_q      <= 1'b0;
            last_cart_q <= 1'b0;
            cart_size_q <= '0;
            fill_n_q    <= '0;
            bios_gnt_q  <= 1'b0;
            cart_gnt_q  <= 1'b0;
            bios_do_q   <= 8'hFF;
            cart_do_q   <= 8'hFF;
        end else begin
            state_q     <= state_d;
            dl_q        <= dl_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            cart_q      <= cart_d;
            last_cart_q <= last_cart_d;
            cart_size_q <= cart_size_d;
            fill_n_q    <= fill_n_d;
            bios_gnt_q  <= bios_gnt_d;
            cart_gnt_q  <= cart_gnt_d;
            bios_do_q   <= bios_do_d;
            cart_do_q   <= cart_do_d;
        end
    end

    // Status outputs.
    always_comb begin
        ioctl_wait = (state_q == ST_HI);
        busy       = (state_q != ST_IDLE);
        cart_size  = cart_size_q;
        bios_do    = bios_do_q;
        cart_do    = cart_do_q;
    end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter with a byte-wide memory model and a
// write scoreboard of expected {address, data} pairs.
module tb_rom_load_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic [12:0] bios_addr;
    logic        bios_cs_n;
    logic [7:0]  bios_do;
    logic [12:0] cart_addr;
    logic        cart_cs_n;
    logic [7:0]  cart_do;
    logic [13:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_q;
    logic [13:0] cart_size;
    logic        busy;

    logic [7:0]  mem [0:16383];
    logic [21:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wait_cnt = 0;

    rom_load_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .bios_addr(bios_addr), .bios_cs_n(bios_cs_n), .bios_do(bios_do),
        .cart_addr(cart_addr), .cart_cs_n(cart_cs_n), .cart_do(cart_do),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_q(mem_q),
        .cart_size(cart_size), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Single-port memory with registered read data.
    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_q <= mem[mem_addr];
    end

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk_sys) begin
        logic [21:0] obs, expv;
        if (ioctl_wait === 1'b1) wait_cnt++;
        if (mem_we === 1'b1) begin
            obs  = {mem_addr, mem_din};
            expv = (exp_q.size() != 0) ? exp_q.pop_front() : 22'bx;
            checks++;
            assert (obs === expv) else begin
                errors++;
                $error("FAIL mem_write observed=%h expected=%h", obs, expv);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_word(input logic [7:0] idx, input logic [24:0] a,
                             input logic [15:0] d, input bit exp_wr);
        if (exp_wr) begin
            exp_q.push_back({idx[0], a[12:0], d[7:0]});
            exp_q.push_back({idx[0], a[12:0] + 13'd1, d[15:8]});
        end
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
        tick();
    endtask

    initial begin
        int  w0;
        int  guard;
        bit  hit;

        reset = 1'b1;
        ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0;
        bios_addr = '0; bios_cs_n = 1'b1; cart_addr = '0; cart_cs_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_wait",      32'(ioctl_wait), 32'd0);
        chk("rst_we",        32'(mem_we),     32'd0);
        chk("rst_mem_addr",  32'(mem_addr),   32'd0);
        chk("rst_mem_din",   32'(mem_din),    32'd0);
        chk("rst_bios_do",   32'(bios_do),    32'hFF);
        chk("rst_cart_do",   32'(cart_do),    32'hFF);
        chk("rst_cart_size", 32'(cart_size),  32'd0);
        @(posedge clk_sys); #1;
        reset = 1'b0;
        tick();

        // BIOS download of two words
        w0 = wait_cnt;
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        tick();
        @(negedge clk_sys);
        chk("busy_rise", 32'(busy), 32'd1);
        tick();
        send_word(8'd0, 25'd0, 16'h3412, 1'b1);
        send_word(8'd0, 25'd2, 16'hAB00, 1'b1);
        chk("bios_wait_pulses", 32'(wait_cnt - w0), 32'd2);
        ioctl_download = 1'b0;
        tick();
        @(negedge clk_sys);
        chk("bios_done_busy", 32'(busy), 32'd0);
        chk("bios_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4-byte cartridge followed by padding of the rest of the region
        @(posedge clk_sys); #1;
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        tick();
        send_word(8'd1, 25'd0, 16'h1100, 1'b1);
        send_word(8'd1, 25'd2, 16'h3322, 1'b1);
        for (int n = 4; n < 8192; n++) exp_q.push_back({14'h2000 + 14'(n), 8'hFF});
        ioctl_download = 1'b0;
        tick();
        @(negedge clk_sys);
        chk("cart_size_4", 32'(cart_size), 32'd4);
        chk("fill_busy", 32'(busy), 32'd1);
        hit = 1'b0;
        guard = 0;
        while (!hit && guard < 9000) begin
            if (mem_we === 1'b1 && mem_addr === 14'h3FFF) hit = 1'b1;
            else begin
                @(negedge clk_sys);
                guard++;
            end
        end
        chk("fill_last_seen", 32'(hit), 32'd1);
        @(negedge clk_sys);
        chk("fill_done_busy", 32'(busy), 32'd0);
        chk("fill_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("fill_size_kept", 32'(cart_size), 32'd4);

        // BIOS read of byte 1
        @(posedge clk_sys); #1;
        bios_addr = 13'd1;
        bios_cs_n = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("bios_rd_1", 32'(bios_do), 32'h34);
        chk("cart_hold_1", 32'(cart_do), 32'hFF);

        // Both selects low: BIOS wins, then cartridge alone
        @(posedge clk_sys); #1;
        bios_addr = 13'd0;
        cart_addr = 13'd0;
        cart_cs_n = 1'b0;
        @(negedge clk_sys);
        chk("both_sel_addr", 32'(mem_addr), 32'h0000);
        @(posedge clk_sys); #1;
        bios_cs_n = 1'b1;
        @(negedge clk_sys);
        chk("cart_sel_addr", 32'(mem_addr), 32'h2000);
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("both_bios_do", 32'(bios_do), 32'h12);
        chk("both_cart_hold", 32'(cart_do), 32'hFF);
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("cart_rd_0", 32'(cart_do), 32'h00);
        chk("bios_hold", 32'(bios_do), 32'h12);
        @(posedge clk_sys); #1;
        cart_cs_n = 1'b1;

        // Cartridge word beyond the region: no write, handshake still runs
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        tick();
        w0 = wait_cnt;
        send_word(8'd1, 25'd8192, 16'hBEEF, 1'b0);
        chk("oor_wait_pulse", 32'(wait_cnt - w0), 32'd1);
        ioctl_download = 1'b0;
        tick();
        @(negedge clk_sys);
        chk("oor_cart_size_sat", 32'(cart_size), 32'd8192);
        chk("oor_no_fill_busy", 32'(busy), 32'd0);

        // Unsupported index: strobe ignored, no wait pulse
        @(posedge clk_sys); #1;
        ioctl_index = 8'd2;
        ioctl_download = 1'b1;
        tick();
        w0 = wait_cnt;
        send_word(8'd2, 25'd4, 16'h7777, 1'b0);
        chk("idx2_no_wait", 32'(wait_cnt - w0), 32'd0);
        ioctl_download = 1'b0;
        tick();
        @(negedge clk_sys);
        chk("idx2_idle", 32'(busy), 32'd0);

        // Reset in the middle of a fill
        @(posedge clk_sys); #1;
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        tick();
        send_word(8'd1, 25'd0, 16'h5566, 1'b1);
        for (int n = 2; n <= 100; n++) exp_q.push_back({14'h2000 + 14'(n), 8'hFF});
        ioctl_download = 1'b0;
        tick();
        hit = 1'b0;
        guard = 0;
        while (!hit && guard < 500) begin
            @(negedge clk_sys);
            if (mem_we === 1'b1 && mem_addr === 14'h2064) hit = 1'b1;
            guard++;
        end
        chk("fill_n100_seen", 32'(hit), 32'd1);
        @(posedge clk_sys); #1;
        reset = 1'b1;
        @(negedge clk_sys);
        chk("rstfill_busy", 32'(busy), 32'd0);
        chk("rstfill_we", 32'(mem_we), 32'd0);
        chk("rstfill_wait", 32'(ioctl_wait), 32'd0);
        chk("rstfill_bios_do", 32'(bios_do), 32'hFF);
        chk("rstfill_sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk_sys); #1;
        reset = 1'b0;
        tick();
        @(negedge clk_sys);
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_load_arbiter.md
# rom_load_arbiter

Single-port ROM arbiter and download sequencer for the Astrocade core. It owns one shared 16 KiB byte-wide memory: BIOS at 0x0000–0x1FFF, cartridge at 0x2000–0x3FFF. The block unpacks 16-bit HPS download words into byte writes, pads short cartridges, and serves BALLY's BIOS and cartridge read ports from the same memory. It sits between hps_io, the BALLY core, and one dpram instance.

## Interface
Parameters:
- REGION_AW, 13: address width of each region (8 KiB).
- FILL_BYTE, 8'hFF: pad value for unused cartridge space.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high. Connects to power-on/user reset only, never to the CPU reset that includes ioctl_download.
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  0 = BIOS, 1 = cartridge, other values are ignored
- ioctl_wr  in  1  one-cycle word strobe
- ioctl_addr  in  25  byte address of the word (even)
- ioctl_dout  in  16  word; low byte goes to the even address
- ioctl_wait  out  1  stalls hps_io while the high byte is written
- bios_addr  in  13  BIOS read address
- bios_cs_n  in  1  BIOS select, active low
- bios_do  out  8  BIOS read data (registered)
- cart_addr  in  13  cartridge read address
- cart_cs_n  in  1  cartridge select, active low
- cart_do  out  8  cartridge read data (registered)
- mem_addr  out  14  shared memory address
- mem_din  out  8  shared memory write data
- mem_we  out  1  shared memory write enable
- mem_q  in  8  shared memory read data; 1-cycle registered output
- cart_size  out  14  bytes loaded into the cartridge region, saturating at 8192
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, HI, FILL.
- IDLE serves CPU reads. If bios_cs_n=0, the BIOS port wins and mem_addr = {0, bios_addr}. Else if cart_cs_n=0, mem_addr = {1, cart_addr}. mem_we = 0.
- IDLE → LOAD on rising edge of ioctl_download. If ioctl_index = 1, cart_size is cleared on entry.
- LOAD: on ioctl_wr with index 0 or 1:
  - Latch the word and address.
  - Write the low byte to {index[0], ioctl_addr[12:0]}.
  - Assert ioctl_wait.
  - Go to HI.
- HI: write the high byte to address + 1. If index = 1, set cart_size = min(8192, max(cart_size, ioctl_addr + 2)). Release ioctl_wait and return to LOAD.
- In LOAD or HI, writes with ioctl_addr ≥ 8192 are suppressed (mem_we = 0). The handshake still completes normally.
- ioctl_wr for other index values: ignored; ioctl_wait stays low.
- Falling edge of ioctl_download in LOAD:
  - If the last index was 1 and cart_size < 8192, go to FILL.
  - Otherwise go to IDLE.
- A falling edge while in HI finishes HI first, then applies the same rule.
- FILL: write FILL_BYTE at 0x2000 + n, one byte per cycle, for n = cart_size … 8191. Then go to IDLE. cart_size itself is unchanged.
- An ioctl_download rising edge during FILL aborts the fill and goes to LOAD.
- Read data path:
  - The port granted in cycle t is recorded.
  - In cycle t+1, mem_q is latched into that port's output register (bios_do or cart_do).
  - Outputs of non-granted ports hold their previous value.
  - Outside IDLE, the captured value is 8'hFF.

## Timing
- Reset values: state IDLE, ioctl_wait 0, mem_we 0, mem_addr 0, mem_din 0, bios_do 8'hFF, cart_do 8'hFF, cart_size 0, busy 0.
- Reset asserted mid-download or mid-fill: immediate return to IDLE, ioctl_wait released, partial memory contents kept.
- Read latency: 2 clk_sys from a stable address and cs_n to valid data. This fits within one clk_cpu_en period pair.
- Download throughput: 2 cycles per word. ioctl_wait is high for exactly 1 cycle per accepted word.
- busy rises the cycle after the download rising edge and falls the cycle after the last FILL write.
- Simultaneous bios_cs_n = cart_cs_n = 0: BIOS is served; cart_do holds.

## Structure
- Shared package astro_pkg holds:
  - region base constants (BIOS_BASE = 0, CART_BASE = 14'h2000)
  - REGION_SIZE = 8192
  - the state enum
- No sub-module. The dpram instance stays in the top level.

## Test plan
- Load BIOS words 0x3412 at addr 0 and 0xAB00 at addr 2 → mem writes (0x0000, 12), (0x0001, 34), (0x0002, 00), (0x0003, AB). ioctl_wait pulses once per word.
- Load a 4-byte cart, then drop ioctl_download:
  - cart_size = 4.
  - FILL writes 8'hFF to 0x2004–0x3FFF (8188 writes).
  - Then IDLE and busy = 0.
- After loads, bios_cs_n = 0, bios_addr = 1 → bios_do = 34 two cycles later, cart_do unchanged.
- Both selects low with cart_addr = 0 → BIOS served. Next cycle, cart_cs_n alone → cart_do = 8'h00 two cycles later.
- Cart word at ioctl_addr = 8192 → no mem_we, ioctl_wait still pulses, cart_size saturates at 8192.
- Assert reset during FILL at n = 100 → next cycle IDLE, mem_we = 0, ioctl_wait = 0, bios_do = 8'hFF.
